// File: rtl/ai_ram_dma_loader.sv
// DMA writer: drains a valid/ready sample stream into an AI RAM sector as one
// registered byte write per cycle, starting at a commanded base address.
module ai_ram_dma_loader #(
    parameter int ADDR_W = 14,
    parameter int LEN_W  = 15,
    parameter bit WIDE   = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [LEN_W-1:0]  length,
    input  logic              abort,
    input  logic              s_valid,
    input  logic [15:0]       s_data,
    output logic              s_ready,
    output logic              q_write,
    output logic [ADDR_W-1:0] q_addr,
    output logic [7:0]        q_data,
    output logic              busy,
    output logic              done,
    output logic              err
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HI   = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    // One extra bit so a full-sector transfer (2^ADDR_W bytes) is representable.
    localparam logic [LEN_W:0] MAX_LEN = {{LEN_W{1'b0}}, 1'b1} << ADDR_W;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   ptr_q;
    logic [LEN_W-1:0]    rem_q;
    logic [LEN_W-1:0]    rem_dec;
    logic [7:0]          hi_q;
    logic                q_write_q;
    logic [ADDR_W-1:0]   q_addr_q;
    logic [7:0]          q_data_q;
    logic                err_q;

    logic                len_ok;
    logic                s_ready_c;
    logic                wr_lo;
    logic                wr_hi;
    logic                cmd_accept;
    logic                cmd_reject;

    assign rem_dec = rem_q - LEN_W'(1);
    assign len_ok  = (length != '0) && ({1'b0, length} <= MAX_LEN);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (start && !abort && len_ok) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (abort) begin
                    state_d = ST_IDLE;
                end else if (s_valid) begin
                    if (rem_dec == '0) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = WIDE ? ST_HI : ST_RUN;
                    end
                end
            end
            ST_HI: begin
                if (abort) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = (rem_dec == '0) ? ST_DONE : ST_RUN;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Abort suppresses both the handshake and the pending high-byte write.
    always_comb begin
        s_ready_c  = 1'b0;
        wr_lo      = 1'b0;
        wr_hi      = 1'b0;
        cmd_accept = 1'b0;
        cmd_reject = 1'b0;
        case (state_q)
            ST_IDLE: begin
                cmd_accept = start && !abort && len_ok;
                cmd_reject = start && !abort && !len_ok;
            end
            ST_RUN: begin
                s_ready_c = !abort;
                wr_lo     = s_valid && !abort;
            end
            ST_HI: begin
                wr_hi = !abort;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr_q     <= '0;
            rem_q     <= '0;
            hi_q      <= '0;
            q_write_q <= 1'b0;
            q_addr_q  <= '0;
            q_data_q  <= '0;
            err_q     <= 1'b0;
        end else begin
            q_write_q <= wr_lo || wr_hi;
            err_q     <= cmd_reject;
            if (cmd_accept) begin
                ptr_q <= base_addr;
                rem_q <= length;
            end
            if (wr_lo) begin
                q_addr_q <= ptr_q;
                q_data_q <= s_data[7:0];
                hi_q     <= s_data[15:8];
                ptr_q    <= ptr_q + ADDR_W'(1);
                rem_q    <= rem_dec;
            end
            if (wr_hi) begin
                q_addr_q <= ptr_q;
                q_data_q <= hi_q;
                ptr_q    <= ptr_q + ADDR_W'(1);
                rem_q    <= rem_dec;
            end
        end
    end

    assign s_ready = s_ready_c;
    assign q_write = q_write_q;
    assign q_addr  = q_addr_q;
    assign q_data  = q_data_q;
    assign busy    = (state_q != ST_IDLE);
    assign done    = (state_q == ST_DONE);
    assign err     = err_q;

endmodule

// File: tb/tb_ai_ram_dma_loader.sv
// Scoreboard bench for ai_ram_dma_loader: a byte-wide and a 16-bit-sample
// instance, directed stimulus pushes expected writes, a monitor pops them.
module tb_ai_ram_dma_loader;

    typedef struct {
        logic [13:0] addr;
        logic [7:0]  data;
        logic        last;
        int          cyc;
    } item_t;

    logic        clk;
    logic        rst;
    logic        start_s   [2];
    logic [13:0] base_s    [2];
    logic [14:0] len_s     [2];
    logic        abort_s   [2];
    logic        valid_s   [2];
    logic [15:0] data_s    [2];
    logic        s_ready_s [2];
    logic        q_write_s [2];
    logic [13:0] q_addr_s  [2];
    logic [7:0]  q_data_s  [2];
    logic        busy_s    [2];
    logic        done_s    [2];
    logic        err_s     [2];

    item_t       exp0 [$];
    item_t       exp1 [$];
    logic [13:0] a_m [2];
    int          done_cnt [2];
    int          err_cnt [2];
    int          cyc;
    int          checks;
    int          errors;

    ai_ram_dma_loader #(.ADDR_W(14), .LEN_W(15), .WIDE(1'b0)) u0 (
        .clk(clk), .rst(rst), .start(start_s[0]), .base_addr(base_s[0]),
        .length(len_s[0]), .abort(abort_s[0]), .s_valid(valid_s[0]),
        .s_data(data_s[0]), .s_ready(s_ready_s[0]), .q_write(q_write_s[0]),
        .q_addr(q_addr_s[0]), .q_data(q_data_s[0]), .busy(busy_s[0]),
        .done(done_s[0]), .err(err_s[0])
    );

    ai_ram_dma_loader #(.ADDR_W(14), .LEN_W(15), .WIDE(1'b1)) u1 (
        .clk(clk), .rst(rst), .start(start_s[1]), .base_addr(base_s[1]),
        .length(len_s[1]), .abort(abort_s[1]), .s_valid(valid_s[1]),
        .s_data(data_s[1]), .s_ready(s_ready_s[1]), .q_write(q_write_s[1]),
        .q_addr(q_addr_s[1]), .q_data(q_data_s[1]), .busy(busy_s[1]),
        .done(done_s[1]), .err(err_s[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Monitor: every presented write must match the head of the scoreboard.
    always @(negedge clk) begin : mon
        item_t it;
        logic  have;
        if (rst) begin
            for (int i = 0; i < 2; i++) begin
                if (q_write_s[i]) begin
                    have = 1'b0;
                    if (i == 0 && exp0.size() > 0) begin it = exp0.pop_front(); have = 1'b1; end
                    if (i == 1 && exp1.size() > 0) begin it = exp1.pop_front(); have = 1'b1; end
                    if (!have) begin
                        chk("unexpected_write", 32'(q_addr_s[i]), 32'hFFFF_FFFF);
                    end else begin
                        chk("wr_addr", 32'(q_addr_s[i]), 32'(it.addr));
                        chk("wr_data", 32'(q_data_s[i]), 32'(it.data));
                        chk("wr_done", 32'(done_s[i]), 32'(it.last));
                        chk("wr_cycle", 32'(cyc), 32'(it.cyc));
                    end
                end
                if (done_s[i]) begin
                    done_cnt[i]++;
                    chk("done_with_write", 32'(q_write_s[i]), 32'd1);
                end
                if (err_s[i]) err_cnt[i]++;
            end
        end
    end

    task automatic start_cmd(input int i, input int base, input int len, input int ab);
        start_s[i] = 1'b1;
        base_s[i]  = 14'(base);
        len_s[i]   = 15'(len);
        abort_s[i] = (ab != 0);
        a_m[i]     = 14'(base);
        @(posedge clk); #1;
        start_s[i] = 1'b0;
        abort_s[i] = 1'b0;
    endtask

    task automatic beat(input int i, input int v, input int d, input int ab,
                        input int exp_rdy, input int exp_busy,
                        input int push, input int pd, input int last);
        item_t it;
        valid_s[i] = (v != 0);
        data_s[i]  = 16'(d);
        abort_s[i] = (ab != 0);
        @(negedge clk);
        chk("s_ready", 32'(s_ready_s[i]), 32'(exp_rdy));
        chk("busy", 32'(busy_s[i]), 32'(exp_busy));
        if (push != 0) begin
            it.addr = a_m[i];
            it.data = 8'(pd);
            it.last = (last != 0);
            it.cyc  = cyc + 1;
            if (i == 0) exp0.push_back(it); else exp1.push_back(it);
            a_m[i] = a_m[i] + 14'd1;
        end
        @(posedge clk); #1;
        valid_s[i] = 1'b0;
        abort_s[i] = 1'b0;
    endtask

    task automatic wr0(input int v, input int d, input int last);
        beat(0, v, d, 0, 1, 1, v, d & 'hFF, last);
    endtask

    task automatic idle(input int i, input int exp_busy);
        beat(i, 0, 0, 0, 0, exp_busy, 0, 0, 0);
    endtask

    initial begin : stim
        int d0;
        int e0;
        checks = 0;
        errors = 0;
        rst = 1'b0;
        for (int i = 0; i < 2; i++) begin
            start_s[i] = 1'b0; base_s[i] = '0; len_s[i] = '0; abort_s[i] = 1'b0;
            valid_s[i] = 1'b0; data_s[i] = '0; a_m[i] = '0;
            done_cnt[i] = 0; err_cnt[i] = 0;
        end
        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++) begin
            chk("reset_outputs", 32'({q_write_s[i], busy_s[i], done_s[i], err_s[i],
                                      s_ready_s[i], q_addr_s[i], q_data_s[i]}), 32'd0);
        end
        rst = 1'b1;
        @(posedge clk); #1;

        // Byte stream, continuous valid
        d0 = done_cnt[0];
        start_cmd(0, 'h0100, 4, 0);
        wr0(1, 'h11, 0);
        wr0(1, 'h22, 0);
        wr0(1, 'h33, 0);
        wr0(1, 'h44, 1);
        idle(0, 1);
        idle(0, 0);
        chk("t1_done_count", 32'(done_cnt[0] - d0), 32'd1);
        chk("t1_drained", 32'(exp0.size()), 32'd0);

        // Backpressure, with a stray start during RUN that must be ignored
        d0 = done_cnt[0];
        start_cmd(0, 'h00A0, 3, 0);
        wr0(1, 'h01, 0);
        start_s[0] = 1'b1; base_s[0] = 14'h3000; len_s[0] = 15'd1;
        wr0(0, 'h99, 0);
        start_s[0] = 1'b0;
        wr0(0, 'h98, 0);
        wr0(1, 'h02, 0);
        wr0(0, 'h97, 0);
        wr0(1, 'h03, 1);
        idle(0, 1);
        idle(0, 0);
        chk("t3_done_count", 32'(done_cnt[0] - d0), 32'd1);
        chk("t3_drained", 32'(exp0.size()), 32'd0);

        // Bad commands, abort+start collision, full-sector length accepted
        e0 = err_cnt[0];
        start_cmd(0, 'h0000, 0, 0);
        idle(0, 0);
        start_cmd(0, 'h0000, 'h4001, 0);
        idle(0, 0);
        idle(0, 0);
        chk("t4_err_count", 32'(err_cnt[0] - e0), 32'd2);
        start_cmd(0, 'h0010, 'h4000, 1);
        idle(0, 0);
        start_cmd(0, 'h3FF0, 'h4000, 0);
        wr0(0, 0, 0);
        beat(0, 1, 'h55, 1, 0, 1, 0, 0, 0);
        idle(0, 0);
        chk("t4_err_total", 32'(err_cnt[0] - e0), 32'd2);
        chk("t4_no_writes", 32'(exp0.size()), 32'd0);

        // Abort after third handshake, then a clean transfer
        d0 = done_cnt[0];
        start_cmd(0, 'h0200, 8, 0);
        wr0(1, 'hA1, 0);
        wr0(1, 'hA2, 0);
        wr0(1, 'hA3, 0);
        beat(0, 1, 'hA4, 1, 0, 1, 0, 0, 0);
        idle(0, 0);
        chk("t5_no_done", 32'(done_cnt[0] - d0), 32'd0);
        chk("t5_drained", 32'(exp0.size()), 32'd0);
        start_cmd(0, 'h0300, 2, 0);
        wr0(1, 'hB1, 0);
        wr0(1, 'hB2, 1);
        idle(0, 1);
        idle(0, 0);
        chk("t5_restart_done", 32'(done_cnt[0] - d0), 32'd1);

        // 16-bit samples, odd length wrapping through address 0
        d0 = done_cnt[1];
        start_cmd(1, 'h3FFE, 3, 0);
        beat(1, 1, 'hBBAA, 0, 1, 1, 1, 'hAA, 0);
        beat(1, 1, 'hDDCC, 0, 0, 1, 1, 'hBB, 0);
        beat(1, 1, 'hDDCC, 0, 1, 1, 1, 'hCC, 1);
        idle(1, 1);
        idle(1, 0);
        chk("t2_done_count", 32'(done_cnt[1] - d0), 32'd1);
        chk("t2_drained", 32'(exp1.size()), 32'd0);

        // Abort while the high byte is pending
        d0 = done_cnt[1];
        start_cmd(1, 'h0010, 4, 0);
        beat(1, 1, 'h2211, 0, 1, 1, 1, 'h11, 0);
        beat(1, 1, 'h4433, 1, 0, 1, 0, 0, 0);
        idle(1, 0);
        chk("hi_abort_no_done", 32'(done_cnt[1] - d0), 32'd0);
        chk("hi_abort_drained", 32'(exp1.size()), 32'd0);

        // Asynchronous reset mid-transfer
        start_cmd(0, 'h0050, 5, 0);
        wr0(1, 'hC1, 0);
        wr0(1, 'hC2, 0);
        wr0(0, 0, 0);
        #1 rst = 1'b0;
        #1;
        chk("async_reset_outputs", 32'({q_write_s[0], busy_s[0], done_s[0], err_s[0],
                                        s_ready_s[0], q_addr_s[0], q_data_s[0]}), 32'd0);
        chk("t6_drained", 32'(exp0.size()), 32'd0);
        @(posedge clk); #1;
        rst = 1'b1;
        beat(0, 1, 'h77, 0, 0, 0, 0, 0, 0);
        beat(0, 1, 'h78, 0, 0, 0, 0, 0, 0);

        repeat (2) @(posedge clk);
        #1;
        chk("final_drained", 32'(exp0.size() + exp1.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ai_ram_dma_loader.md
Name: ai_ram_dma_loader

Overview:
- DMA writer feeding the write-side port (q_write/q_addr/q_data) of an AI RAM sector.
- Takes a start command carrying a base address and a byte count.
- Pulls samples from a valid/ready stream and emits one registered byte write per cycle into the sector.
- Sits between the audio/feature front-end and the AI RAM. Raises done when the transfer completes.

Parameters:
ADDR_W, 14, sector byte-address width; pointer wraps modulo 2^ADDR_W
LEN_W, 15, width of length field; max transfer 2^ADDR_W bytes
WIDE, 0, 0 = stream carries one byte per beat (s_data[7:0]); 1 = 16-bit samples split into two bytes, low byte first

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  asynchronous active-low reset (asserted at 0)
start  in  1  command strobe, sampled only in IDLE
base_addr  in  ADDR_W  first write address, latched on accepted start
length  in  LEN_W  bytes to write, latched on accepted start
abort  in  1  cancel current transfer
s_valid  in  1  stream data valid
s_data  in  16  stream sample (upper byte ignored when WIDE=0)
s_ready  out  1  loader can accept a beat
q_write  out  1  registered byte-write strobe to RAM sector
q_addr  out  ADDR_W  registered write address
q_data  out  8  registered write byte
busy  out  1  transfer in progress
done  out  1  one-cycle completion pulse
err  out  1  one-cycle pulse: start with length 0 or length > 2^ADDR_W

Behaviour:
- Reset (rst=0, async) forces these values:
  - state IDLE; all outputs 0.
  - ptr, remaining and the hi-byte register cleared.
- States: IDLE, RUN, HI (WIDE=1 only), DONE.
- IDLE:
  - On start: length==0 or length>2^ADDR_W -> err=1 next cycle, remain IDLE.
  - Otherwise latch ptr=base_addr, remaining=length, go RUN.
  - Start in any other state is ignored.
- RUN:
  - s_ready=1 combinationally (state==RUN and abort=0).
  - Handshake s_valid&s_ready writes the low byte. Next cycle: q_write=1, q_addr=ptr, q_data=s_data[7:0].
  - Same edge: ptr+=1 (wrap 2^ADDR_W-1 -> 0), remaining-=1.
  - WIDE=1: high byte stored. Go HI if remaining after decrement > 0, else DONE.
  - WIDE=0: stay RUN if remaining after decrement > 0, else DONE.
  - No handshake: q_write=0 next cycle; q_addr/q_data hold their last values.
- HI:
  - s_ready=0.
  - Next cycle: q_write=1, q_addr=ptr, q_data=stored high byte.
  - ptr+=1, remaining-=1. Go RUN if remaining > 0, else DONE.
- Odd length with WIDE=1: high byte of the final sample is discarded; no extra write.
- DONE:
  - done=1 for exactly one cycle; s_ready=0; go IDLE.
  - The last q_write is visible in the same cycle as done.
- busy=1 in RUN, HI and DONE; busy=0 in IDLE.
- Write latency: 1 cycle from handshake edge to q_write. Throughput:
  - WIDE=0: 1 byte/cycle.
  - WIDE=1: 2 bytes per 2 cycles.
- abort:
  - Any non-IDLE state -> IDLE on next edge.
  - s_ready forced 0 in the abort cycle.
  - No write launched from that cycle; no done.
  - A q_write already registered from the previous cycle still completes.
- abort and start in the same IDLE cycle: abort wins, start ignored.
- Wrap-around: base_addr near top of sector plus length wraps the address through 0, no error.
- ptr is ADDR_W bits; remaining is LEN_W bits.
- At most one q_write per cycle. q_write is never asserted in IDLE except the one cycle after the final or aborted write.

Test Plan:
- WIDE=0, base 0x0100, length 4, s_valid held 1, data 0x11,0x22,0x33,0x44:
  - Required: q_write on 4 consecutive cycles at 0x0100..0x0103 with those bytes.
  - done coincident with the 4th write; busy low the cycle after.
- WIDE=1, base 0x3FFE, length 3, samples 0xBBAA, 0xDDCC:
  - Required writes: 0x3FFE=0xAA, 0x3FFF=0xBB, 0x0000=0xCC.
  - 0xDD dropped; done pulses once.
- Backpressure: WIDE=0, length 3, s_valid toggling 1,0,0,1,0,1:
  - Required: exactly 3 writes, each one cycle after its handshake; addresses contiguous.
- Bad command: start with length 0, then length 0x4001:
  - Required: err pulses twice, busy stays 0, no q_write.
- Abort: length 8, abort asserted after 3rd handshake:
  - Required: 3 writes only; IDLE next cycle; done never asserted.
  - A new start then runs normally.
- Reset mid-transfer: rst=0 asynchronously during RUN:
  - Required: outputs 0 immediately; after release, s_ready=0 until a new start.
